// File: rtl/xpb_table_gen_if.sv
// xpb_table_gen_if: request (start/modulus/exponent) and table-write (busy/wr_en/wr_addr/wr_data/done) bundle; master = requester, slave = generator
interface xpb_table_gen_if #(
  parameter int WIDTH    = 1024,
  parameter int IDX_BITS = 5,
  parameter int EXP_W    = 11
);
  logic                start;
  logic [WIDTH-1:0]    modulus;
  logic [EXP_W-1:0]    exponent;
  logic                busy;
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                done;
  modport master (output start, modulus, exponent, input busy, wr_en, wr_addr, wr_data, done);
  modport slave  (input start, modulus, exponent, output busy, wr_en, wr_addr, wr_data, done);
endinterface

// File: rtl/xpb_table_gen.sv
// xpb_table_gen: writes entry[i] = i*2^e mod N for all 2^IDX_BITS indices; ports clk, reset (sync, high), bus (slave: start/modulus/exponent in, busy/wr_en/wr_addr/wr_data/done out)
module xpb_table_gen #(
  parameter int WIDTH    = 1024,
  parameter int IDX_BITS = 5,
  parameter int EXP_W    = 11
) (
  input  logic               clk,
  input  logic               reset,
  xpb_table_gen_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, POW, GEN, DONE} state_t;
  state_t              state_q;
  logic [WIDTH-1:0]    n_q, acc_q, base_q, run_q, acc_d, run_d;
  logic [EXP_W-1:0]    cnt_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [WIDTH:0]      dbl, dbl_sub, sum, sum_sub;
  assign dbl     = {acc_q, 1'b0};
  assign dbl_sub = dbl - {1'b0, n_q};
  assign sum     = {1'b0, run_q} + {1'b0, base_q};
  assign sum_sub = sum - {1'b0, n_q};
  always_comb begin
    acc_d = dbl >= {1'b0, n_q} ? dbl_sub[WIDTH-1:0] : dbl[WIDTH-1:0];
    run_d = sum >= {1'b0, n_q} ? sum_sub[WIDTH-1:0] : sum[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      run_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          n_q     <= bus.modulus;
          cnt_q   <= bus.exponent;
          acc_q   <= WIDTH'(1);
          state_q <= POW;
        end
        POW: if (cnt_q != '0) begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - EXP_W'(1);
        end else begin
          base_q  <= acc_q;
          run_q   <= '0;
          idx_q   <= '0;
          state_q <= GEN;
        end
        GEN: begin
          run_q <= run_d;
          idx_q <= idx_q + IDX_BITS'(1);
          if (&idx_q) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy    = state_q != IDLE;
  assign bus.wr_en   = state_q == GEN;
  assign bus.done    = state_q == DONE;
  assign bus.wr_addr = idx_q;
  assign bus.wr_data = run_q;
endmodule

// File: tb/tb_xpb_table_gen.sv
// tb_xpb_table_gen: directed and random table runs checked against a big-integer i*2^e mod N model
module tb_xpb_table_gen;
  localparam int W  = 1024;
  localparam int IB = 5;
  localparam int EW = 11;
  localparam int D  = 1 << IB;
  localparam int BW = (1 << EW) + IB + 1;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] last;
  xpb_table_gen_if #(.WIDTH(W), .IDX_BITS(IB), .EXP_W(EW)) bus ();
  xpb_table_gen #(.WIDTH(W), .IDX_BITS(IB), .EXP_W(EW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed(lo64)=%0h expected(lo64)=%0h", tag, obs[63:0], want[63:0]);
    end
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [W-1:0] ref_entry(input logic [W-1:0] n, input int e, input int i);
    logic [BW-1:0] big;
    logic [BW-1:0] r;
    big = BW'(i) << e;
    r = big % BW'(n);
    return r[W-1:0];
  endfunction

  task automatic run(input logic [W-1:0] n, input int e, input int abort_at, input bit noise, input string tag);
    bus.start = 1;
    bus.modulus = n;
    bus.exponent = EW'(e);
    step;
    bus.start = noise;
    for (int j = 0; j <= e; j++) begin
      if (noise) begin
        bus.modulus = rand_wide() | W'(1);
        bus.exponent = EW'($urandom());
      end
      chk({tag, " pow ctl"}, W'({bus.busy, bus.wr_en, bus.done}), W'(3'b100));
      step;
    end
    for (int i = 0; i < D; i++) begin
      if (noise) begin
        bus.modulus = rand_wide() | W'(1);
        bus.exponent = EW'($urandom());
      end
      chk({tag, " gen ctl"}, W'({bus.busy, bus.wr_en, bus.done}), W'(3'b110));
      chk({tag, " gen addr"}, W'(bus.wr_addr), W'(i));
      chk({tag, " gen data"}, bus.wr_data, ref_entry(n, e, i));
      chk({tag, " data<N"}, W'(bus.wr_data < n), W'(1));
      last = bus.wr_data;
      if (i == abort_at) begin
        reset = 1;
        bus.start = 1;
        step;
        reset = 0;
        bus.start = 0;
        chk({tag, " rst ctl"}, W'({bus.busy, bus.wr_en, bus.done}), W'(3'b000));
        chk({tag, " rst addr"}, W'(bus.wr_addr), W'(0));
        chk({tag, " rst data"}, bus.wr_data, W'(0));
        for (int k = 0; k < 40; k++) begin
          step;
          chk({tag, " quiet"}, W'({bus.busy, bus.wr_en, bus.done}), W'(3'b000));
        end
        return;
      end
      step;
    end
    chk({tag, " done ctl"}, W'({bus.busy, bus.wr_en, bus.done}), W'(3'b101));
    bus.start = noise;
    bus.modulus = n;
    step;
    bus.start = 0;
    chk({tag, " idle ctl"}, W'({bus.busy, bus.wr_en, bus.done}), W'(3'b000));
    step;
    chk({tag, " stay idle"}, W'({bus.busy, bus.wr_en, bus.done}), W'(3'b000));
  endtask

  initial begin
    logic [W-1:0] n;
    int e;
    bus.start = 1;
    bus.modulus = W'(13);
    bus.exponent = EW'(3);
    step;
    step;
    bus.start = 0;
    chk("reset busy", W'(bus.busy), W'(0));
    chk("reset wr_en", W'(bus.wr_en), W'(0));
    chk("reset done", W'(bus.done), W'(0));
    chk("reset addr", W'(bus.wr_addr), W'(0));
    chk("reset data", bus.wr_data, W'(0));
    reset = 0;
    step;
    chk("idle no start", W'(bus.busy), W'(0));
    run(W'(13), 2, -1, 0, "n13e2");
    chk("n13e2 entry31", last, W'(7));
    run(W'(7), 0, -1, 0, "n7e0");
    chk("n7e0 entry31", last, W'(3));
    run('1, 1024, -1, 0, "nmax");
    chk("nmax entry31", last, W'(31));
    run(W'(13), 2, 9, 0, "abort");
    run(W'(13), 5, -1, 0, "post abort");
    run(rand_wide() | W'(1), 20, -1, 1, "noise");
    for (int r = 0; r < 50; r++) begin
      n = rand_wide() | W'(1);
      if (n < W'(2)) n[1] = 1'b1;
      e = (r % 2 == 1) ? int'($urandom_range(0, (1 << EW) - 1)) : int'($urandom_range(0, 255));
      run(n, e, -1, 0, "random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xpb_table_gen.md
XPB_TABLE_GEN -- requirements
Module: xpb_table_gen

Interface
REQ-001 Parameter WIDTH, default 1024, bit width of the modulus and of each table entry.
REQ-002 Parameter IDX_BITS, default 5, table index width; table depth is 2^IDX_BITS entries.
REQ-003 Parameter EXP_W, default 11, width of the exponent input.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request generation of one table; sampled only in IDLE.
REQ-007 modulus  input  WIDTH  modulus N; sampled in the cycle start is accepted.
REQ-008 exponent  input  EXP_W  bit position e of the table; sampled in the cycle start is accepted.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 wr_en  output  1  table write strobe toward the lookup-table storage.
REQ-011 wr_addr  output  IDX_BITS  table index being written.
REQ-012 wr_data  output  WIDTH  entry value i*2^e mod N for index i = wr_addr.
REQ-013 done  output  1  one-cycle pulse after the last entry is written.

Function
REQ-014 The block SHALL produce, for i = 0 .. 2^IDX_BITS-1, entry[i] = (i * 2^e) mod N, fully reduced (0 <= entry < N).
REQ-015 Caller SHALL hold 2 <= N < 2^WIDTH; behaviour for N < 2 is unspecified and not verified.
REQ-016 States: IDLE, POW, GEN, DONE; all outputs SHALL be decoded from registered state only (no input-to-output combinational path).
REQ-017 IDLE: start=1 SHALL latch N and e, set acc=1 mod N, set cnt=e, go to POW; start=0 stays in IDLE.
REQ-018 POW: if cnt!=0, acc <= (2*acc >= N) ? 2*acc-N : 2*acc using a WIDTH+1-bit intermediate, cnt decrements; if cnt==0, base <= acc, run <= 0, idx <= 0, go to GEN.
REQ-019 POW SHALL occupy exactly e+1 cycles.
REQ-020 GEN: each cycle wr_en=1, wr_addr=idx, wr_data=run; next run <= (run+base >= N) ? run+base-N : run+base with WIDTH+1-bit sum; idx increments.
REQ-021 GEN SHALL occupy exactly 2^IDX_BITS cycles; when idx equals all-ones go to DONE (no idx wrap-around write).
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-023 Latency: start accepted at cycle T -> first wr_en at T+e+2, last wr_en at T+e+1+2^IDX_BITS, done at T+e+2+2^IDX_BITS.
REQ-024 wr_en SHALL be 0 in IDLE, POW and DONE; writes SHALL be strictly ascending addresses 0..2^IDX_BITS-1 with no gaps.
REQ-025 start while busy=1 SHALL be ignored; modulus/exponent changes while busy SHALL not affect the run in progress.
REQ-026 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.

Reset
REQ-027 reset=1 SHALL force state IDLE and busy=0, wr_en=0, done=0, wr_addr=0, wr_data=0 on the next edge, overriding start.
REQ-028 reset asserted mid-POW or mid-GEN SHALL abort the run; no further wr_en or done pulse SHALL occur until a new start.
REQ-029 Internal acc, base, run, cnt, idx SHALL reset to 0.

Verification
REQ-030 N=13, e=2, start at cycle T -> wr_en T+4..T+35, data 0,4,8,12,3,7,11,2,... entry[31]=7, done at T+36.
REQ-031 N=7, e=0 -> base=1, entries i mod 7, entry[31]=3, first wr_en at T+2.
REQ-032 WIDTH=1024, N=2^1024-1, e=1024 -> base=1, entry[i]=i; checks WIDTH+1-bit carry path.
REQ-033 Random odd 1024-bit N, random e < 2^EXP_W, 50 runs -> all 32 entries match software model i*2^e mod N; each < N.
REQ-034 reset asserted on 10th GEN cycle -> next cycle busy=0, wr_en=0; no done; subsequent start produces full correct table.
REQ-035 start pulsed during POW and GEN with different N -> ignored; table matches originally latched N and e; busy stays 1 until DONE.
